// File: rtl/cf_fft_256_8_seq.sv
// cf_fft_256_8_seq: butterfly sequencer for an in-place radix-2 DIT FFT.
// Walks LOG2N stages of N/2 butterflies, drives operand read addresses,
// a twiddle index aligned with returning RAM data, and write-back addresses
// delayed to line up with the butterfly results. A drain gap between stages
// lets the last write of a stage land before the next stage reads.
//
// Strobe semantics: rd_en and wr_en are qualified by en. A transfer (read
// issue or write-back) happens only in a cycle where the strobe and en are
// both high. While en is low every register, and so every output except
// bf_en, holds its value, so a strobe may stay high across stalled cycles.
module cf_fft_256_8_seq #(
   parameter int LOG2N  = 8,
   parameter int RD_LAT = 1,
   parameter int BF_LAT = 4
) (
   input  logic             clock_c,
   input  logic             reset_n,
   input  logic             start,
   input  logic             en,
   output logic             bf_en,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_idx,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b,
   output logic [3:0]       stage,
   output logic             busy,
   output logic             done
);

   localparam int WB_DLY = RD_LAT + BF_LAT;
   localparam int CW     = $clog2(WB_DLY + 1);

   localparam logic [CW-1:0]    CNT_INIT = CW'(WB_DLY);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [3:0]       S_LAST   = 4'(LOG2N - 1);
   localparam logic [LOG2N-2:0] K_LAST   = '1;
   localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       s_q, s_d;
   logic [LOG2N-2:0] k_q, k_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;

   // Issue-side combinational values.
   logic [LOG2N-1:0] k_ext;
   logic [LOG2N-1:0] low_mask;
   logic [LOG2N-1:0] addr_a;
   logic [LOG2N-1:0] addr_b;
   logic [LOG2N-2:0] tw_calc;
   logic [LOG2N-2:0] tw_issue;

   // Delay lines: twiddle (RD_LAT deep) and write-back (WB_DLY deep).
   logic [LOG2N-2:0] tw_pipe_q [RD_LAT];
   logic [LOG2N-2:0] tw_pipe_d [RD_LAT];
   logic [WB_DLY-1:0] wen_pipe_q, wen_pipe_d;
   logic [LOG2N-1:0] wa_pipe_q [WB_DLY];
   logic [LOG2N-1:0] wa_pipe_d [WB_DLY];
   logic [LOG2N-1:0] wb_pipe_q [WB_DLY];
   logic [LOG2N-1:0] wb_pipe_d [WB_DLY];

   // State register: FSM, stage/butterfly/drain counters and done pulse.
   always_ff @(posedge clock_c or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         s_q     <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Next state: everything holds when en is low. A start in the cycle
   // that shows done is ignored so back-to-back transforms see one idle cycle.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      if (en) begin
         done_d = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && !done_q) begin
                  state_d = S_RUN;
                  s_d     = '0;
                  k_d     = '0;
               end
            end
            S_RUN: begin
               if (k_q == K_LAST) begin
                  state_d = S_DRAIN;
                  cnt_d   = CNT_INIT;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
            S_DRAIN: begin
               if (cnt_q == CNT_ONE) begin
                  if (s_q == S_LAST) begin
                     state_d = S_IDLE;
                     s_d     = '0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_RUN;
                     s_d     = s_q + 4'd1;
                     k_d     = '0;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs: operand addresses insert a zero at bit s of k; the partner
   // sets that bit. Twiddle is k scaled to the stage's subgroup size.
   always_comb begin
      k_ext     = {1'b0, k_q};
      low_mask  = (ONE << s_q) - ONE;
      addr_a    = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
      addr_b    = addr_a | (ONE << s_q);
      tw_calc   = k_q << (S_LAST - s_q);
      rd_en     = (state_q == S_RUN);
      busy      = (state_q != S_IDLE);
      rd_addr_a = rd_en ? addr_a : '0;
      rd_addr_b = rd_en ? addr_b : '0;
      tw_issue  = rd_en ? tw_calc : '0;
      stage     = s_q;
      done      = done_q;
      bf_en     = en;
   end

   // Delay-line next values: shift by one slot per enabled cycle.
   always_comb begin
      tw_pipe_d  = tw_pipe_q;
      wen_pipe_d = wen_pipe_q;
      wa_pipe_d  = wa_pipe_q;
      wb_pipe_d  = wb_pipe_q;
      if (en) begin
         tw_pipe_d[0] = tw_issue;
         for (int i = 1; i < RD_LAT; i++) tw_pipe_d[i] = tw_pipe_q[i-1];
         wen_pipe_d = {wen_pipe_q[WB_DLY-2:0], rd_en};
         wa_pipe_d[0] = rd_addr_a;
         wb_pipe_d[0] = rd_addr_b;
         for (int i = 1; i < WB_DLY; i++) begin
            wa_pipe_d[i] = wa_pipe_q[i-1];
            wb_pipe_d[i] = wb_pipe_q[i-1];
         end
      end
   end

   // Delay-line registers, cleared on reset.
   always_ff @(posedge clock_c or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < RD_LAT; i++) tw_pipe_q[i] <= '0;
         wen_pipe_q <= '0;
         for (int i = 0; i < WB_DLY; i++) begin
            wa_pipe_q[i] <= '0;
            wb_pipe_q[i] <= '0;
         end
      end else begin
         tw_pipe_q  <= tw_pipe_d;
         wen_pipe_q <= wen_pipe_d;
         wa_pipe_q  <= wa_pipe_d;
         wb_pipe_q  <= wb_pipe_d;
      end
   end

   assign tw_idx    = tw_pipe_q[RD_LAT-1];
   assign wr_en     = wen_pipe_q[WB_DLY-1];
   assign wr_addr_a = wa_pipe_q[WB_DLY-1];
   assign wr_addr_b = wb_pipe_q[WB_DLY-1];

endmodule

// File: tb/tb_cf_fft_256_8_seq.sv
// Bench for cf_fft_256_8_seq. A timeline model maps "enabled cycles since
// start" to the expected outputs using the stage/butterfly schedule directly.
module tb_cf_fft_256_8_seq;

   localparam int LOG2N      = 8;
   localparam int RD_LAT     = 1;
   localparam int BF_LAT     = 4;
   localparam int N          = 1 << LOG2N;
   localparam int HALF       = N / 2;
   localparam int WB         = RD_LAT + BF_LAT;
   localparam int PER        = HALF + WB;
   localparam int LAST_ISSUE = PER * (LOG2N - 1) + HALF;
   localparam int END_T      = LAST_ISSUE + WB;

   logic             clock_c, reset_n, start, en;
   logic             bf_en, rd_en, wr_en, busy, done;
   logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [LOG2N-2:0] tw_idx;
   logic [3:0]       stage;

   cf_fft_256_8_seq #(.LOG2N(LOG2N), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
      .clock_c(clock_c), .reset_n(reset_n), .start(start), .en(en),
      .bf_en(bf_en), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .tw_idx(tw_idx), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
      .stage(stage), .busy(busy), .done(done)
   );

   // Clock and reset defaults.
   initial begin
      clock_c = 1'b0;
      forever #5 clock_c = ~clock_c;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Model state.
   bit running = 0;
   int t_eff   = 0;
   int abs_cyc = 0;
   int stall_cnt;

   // Scoreboard.
   logic [2*LOG2N-1:0] exp_q[$];
   int rd_cnt, wr_cnt, done_cnt, done_cycle, hazard_cnt;
   int hits [LOG2N][N];
   int first_rd [LOG2N];
   int last_wr [LOG2N];

   // Snapshot of the current cycle, consumed on the next enabled edge.
   bit               snap_issue;
   int               snap_a, snap_b, snap_s;
   logic             snap_rd, snap_wr, snap_done;
   logic [LOG2N-1:0] snap_ra, snap_rb, snap_wa, snap_wb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit issue_at(input int t, output int s, output int k);
      int u;
      s = 0;
      k = 0;
      if (t < 1) return 1'b0;
      u = t - 1;
      s = u / PER;
      k = u % PER;
      return (s < LOG2N) && (k < HALF);
   endfunction

   function automatic int ins_zero(input int k, input int s);
      return ((k >> s) << (s + 1)) | (k & ((1 << s) - 1));
   endfunction

   function automatic int tw_of(input int k, input int s);
      return (k << (LOG2N - 1 - s)) % HALF;
   endfunction

   task automatic check_outputs();
      int t, s, k, ea, eb, etw, ewa, ewb, es;
      bit v, ewr;
      t = running ? t_eff : 0;
      v = issue_at(t, s, k);
      ea = v ? ins_zero(k, s) : 0;
      eb = v ? (ea | (1 << s)) : 0;
      snap_issue = v; snap_a = ea; snap_b = eb; snap_s = s;
      chk("rd_en", rd_en, v);
      chk("rd_addr_a", rd_addr_a, ea);
      chk("rd_addr_b", rd_addr_b, eb);
      v = issue_at(t - RD_LAT, s, k);
      etw = v ? tw_of(k, s) : 0;
      chk("tw_idx", tw_idx, etw);
      ewr = issue_at(t - WB, s, k);
      ewa = ewr ? ins_zero(k, s) : 0;
      ewb = ewr ? (ewa | (1 << s)) : 0;
      chk("wr_en", wr_en, ewr);
      chk("wr_addr_a", wr_addr_a, ewa);
      chk("wr_addr_b", wr_addr_b, ewb);
      chk("busy", busy, (t >= 1 && t <= END_T));
      chk("done", done, (t == END_T + 1));
      chk("bf_en", bf_en, en);
      if (t >= 1 && t <= END_T) begin
         es = (t - 1) / PER;
         if (es > LOG2N - 1) es = LOG2N - 1;
         chk("stage", stage, es);
      end
      snap_rd = rd_en; snap_wr = wr_en; snap_done = done;
      snap_ra = rd_addr_a; snap_rb = rd_addr_b;
      snap_wa = wr_addr_a; snap_wb = wr_addr_b;
      if (done === 1'b1 && done_cycle < 0) done_cycle = abs_cyc;
   endtask

   // Book-keeping for the transfer that the coming enabled edge completes.
   task automatic account();
      int ws;
      logic [2*LOG2N-1:0] e;
      if (snap_rd === 1'b1) begin
         rd_cnt++;
         if (snap_issue && snap_s < LOG2N && first_rd[snap_s] < 0) first_rd[snap_s] = abs_cyc;
      end
      if (snap_issue) exp_q.push_back({snap_a[LOG2N-1:0], snap_b[LOG2N-1:0]});
      if (snap_wr === 1'b1) begin
         ws = wr_cnt / HALF;
         wr_cnt++;
         chk("wb_queue_has_entry", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_pair", {snap_wa, snap_wb}, e);
         end
         if (ws < LOG2N) begin
            hits[ws][snap_wa]++;
            hits[ws][snap_wb]++;
            last_wr[ws] = abs_cyc;
         end
         if (snap_rd === 1'b1 && (snap_ra == snap_wa || snap_ra == snap_wb ||
                                  snap_rb == snap_wa || snap_rb == snap_wb))
            hazard_cnt++;
      end
      if (snap_done === 1'b1) done_cnt++;
   endtask

   // One clock: drive inputs, advance model at the edge, check at negedge.
   task automatic step(input logic en_v, input logic start_v);
      en = en_v;
      start = start_v;
      if (en_v) account();
      if (running && !en_v && t_eff <= END_T) stall_cnt++;
      @(posedge clock_c);
      if (running) begin
         if (en_v) begin
            if (t_eff == END_T + 1) begin
               running = 0;
               t_eff = 0;
            end else begin
               t_eff++;
            end
         end
      end else if (en_v && start_v) begin
         running = 1;
         t_eff = 1;
         abs_cyc = 0;
      end
      abs_cyc++;
      @(negedge clock_c);
      check_outputs();
   endtask

   task automatic run_to(input int target);
      int guard = 0;
      while (abs_cyc < target && guard < 20000) begin
         step(1'b1, 1'b0);
         guard++;
      end
      chk("run_to_reached", (abs_cyc >= target), 1);
   endtask

   task automatic reset_stats();
      exp_q.delete();
      rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cycle = -1;
      hazard_cnt = 0; stall_cnt = 0;
      for (int s = 0; s < LOG2N; s++) begin
         first_rd[s] = -1;
         last_wr[s] = -1;
         for (int a = 0; a < N; a++) hits[s][a] = 0;
      end
   endtask

   // Reset asserted in the middle of the low clock phase.
   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      #1;
      running = 0;
      t_eff = 0;
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", {rd_addr_a, rd_addr_b}, 0);
      chk("rst_tw_idx", tw_idx, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", {wr_addr_a, wr_addr_b}, 0);
      chk("rst_stage", stage, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(posedge clock_c);
      @(negedge clock_c);
      reset_n = 1'b1;
      check_outputs();
   endtask

   task automatic end_checks(input int exp_done_cycle);
      int bad;
      chk("rd_count", rd_cnt, HALF * LOG2N);
      chk("wr_count", wr_cnt, HALF * LOG2N);
      chk("done_pulses", done_cnt, 1);
      chk("done_cycle", done_cycle, exp_done_cycle);
      chk("queue_drained", exp_q.size(), 0);
      chk("same_cycle_rw", hazard_cnt, 0);
      for (int s = 0; s < LOG2N; s++) begin
         bad = 0;
         for (int a = 0; a < N; a++) if (hits[s][a] != 1) bad++;
         chk($sformatf("write_cover_s%0d", s), bad, 0);
      end
      for (int s = 0; s < LOG2N - 1; s++)
         chk($sformatf("stage_gap_s%0d", s), (last_wr[s] < first_rd[s+1]), 1);
   endtask

   initial begin
      int guard;
      reset_n = 1'b0;
      start = 1'b0;
      en = 1'b0;
      reset_stats();
      @(negedge clock_c);
      do_reset();

      // Idle: random en, no start; also a start with en low is not taken.
      for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1'b0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      for (int i = 0; i < $urandom_range(1, 6); i++) step(1'b1, 1'b0);

      // Run 1: continuous enable, directed spot checks, second start at 500.
      reset_stats();
      step(1'b1, 1'b1);
      chk("c1_a", rd_addr_a, 0); chk("c1_b", rd_addr_b, 1); chk("c1_tw", tw_idx, 0);
      step(1'b1, 1'b0);
      chk("c2_a", rd_addr_a, 2); chk("c2_b", rd_addr_b, 3); chk("c2_tw", tw_idx, 0);
      run_to(6);
      chk("c6_wr_en", wr_en, 1); chk("c6_wa", wr_addr_a, 0); chk("c6_wb", wr_addr_b, 1);
      run_to(1 + PER * 3 + 9);
      chk("s3k9_a", rd_addr_a, 17); chk("s3k9_b", rd_addr_b, 25); chk("s3k9_stage", stage, 3);
      step(1'b1, 1'b0);
      chk("s3k9_tw", tw_idx, 16);
      run_to(500);
      step(1'b1, 1'b1);
      run_to(1 + PER * 7 + 5);
      chk("s7k5_a", rd_addr_a, 5); chk("s7k5_b", rd_addr_b, 133);
      step(1'b1, 1'b0);
      chk("s7k5_tw", tw_idx, 5);
      run_to(END_T + 4);
      end_checks(1065);

      // Run 2: three stalled cycles in the stage-0 drain.
      reset_stats();
      step(1'b1, 1'b1);
      run_to(130);
      step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      run_to(END_T + 8);
      end_checks(1068);

      // Run 3: random enable throughout.
      reset_stats();
      step(1'b1, 1'b1);
      guard = 0;
      while (running && guard < 6000) begin
         step(1'($urandom_range(0, 7) != 0), 1'b0);
         guard++;
      end
      chk("random_run_completes", running, 0);
      end_checks(END_T + 1 + stall_cnt);

      // Abort at cycle 700, then a clean replay.
      reset_stats();
      step(1'b1, 1'b1);
      run_to(700);
      do_reset();
      chk("abort_no_done", done_cnt, 0);
      reset_stats();
      step(1'b1, 1'b1);
      chk("replay_a", rd_addr_a, 0); chk("replay_stage", stage, 0);
      run_to(END_T + 1);
      step(1'b1, 1'b1);
      chk("start_in_done_ignored", busy, 0);
      end_checks(1065);

      // Start accepted one cycle after done.
      reset_stats();
      step(1'b1, 1'b1);
      chk("restart_busy", busy, 1);
      run_to(150);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cf_fft_256_8_seq.md
# cf_fft_256_8_seq

Butterfly sequencer for the in-place radix-2 DIT FFT datapath. On a start pulse it walks all log2(N) stages, issuing one butterfly per enabled cycle. For each butterfly it drives the read addresses of the operand pair to a synchronous buffer RAM and a twiddle index aligned with the returning data. It also drives matching write-back addresses delayed to meet the butterfly results. It sits directly upstream of the 8-bit-per-component butterfly stage: its outputs drive that stage's twiddle index and enable inputs.

## Interface
- LOG2N, 8, log2 of transform size; N = 2^LOG2N, N/2 butterflies per stage.
- RD_LAT, 1, buffer RAM read latency in cycles.
- BF_LAT, 4, butterfly latency from sampled inputs to valid outputs.
- clock_c  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin transform; sampled only in IDLE.
- en  in  1  global advance enable; low freezes all state, including delay lines.
- bf_en  out  1  combinational copy of en, to the butterfly enable input.
- rd_en  out  1  butterfly issue strobe.
- rd_addr_a, rd_addr_b  out  LOG2N  operand addresses for the issued butterfly.
- tw_idx  out  LOG2N-1  twiddle index, delayed RD_LAT enabled cycles from issue.
- wr_en  out  1  write-back strobe.
- wr_addr_a, wr_addr_b  out  LOG2N  write-back addresses for outputs o1 and o2.
- stage  out  4  current stage index s.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at transform completion.

## Operation
- State machine states: IDLE, RUN, DRAIN.
- IDLE, start=1, en=1: go to RUN with s=0 and k=0. start is ignored in every other state.
- RUN: each enabled cycle asserts rd_en for butterfly k, then increments k. After issuing k=N/2-1, go to DRAIN with drain counter = WB_DLY = RD_LAT+BF_LAT.
- DRAIN: no issue; the counter decrements each enabled cycle.
  - When the counter reaches its final cycle and s<LOG2N-1: increment s, set k=0, return to RUN.
  - When the counter reaches its final cycle and s=LOG2N-1: go to IDLE and pulse done.
- Address rule for stage s and butterfly k:
  - rd_addr_a = k with a 0 bit inserted at bit position s, i.e. {k[LOG2N-2:s], 0, k[s-1:0]}.
  - rd_addr_b = rd_addr_a | (1<<s).
- Twiddle rule: twiddle index = (k << (LOG2N-1-s)) mod N/2, computed at issue and delayed RD_LAT cycles onto tw_idx.
- Write-back: rd_en, rd_addr_a and rd_addr_b pass through a WB_DLY-deep shift register, advanced only when en=1, to produce wr_en, wr_addr_a and wr_addr_b.
- Hazard rule: the drain gap guarantees the last write of stage s occurs strictly before the first read of stage s+1. A same-cycle read/write of one address never occurs.
- en=0: all registers hold, including FSM, counters and delay lines; outputs stay stable.
- Reset values: all outputs 0, FSM=IDLE, s=0, k=0, delay lines cleared. Reset asserted mid-transform aborts it immediately with no done pulse.

## Timing
- Start sampled high at edge of cycle 0 (en continuously high): first rd_en in cycle 1.
- Stage s issue cycles: 1+(N/2+WB_DLY)·s through that value + N/2-1. With defaults, stage s issues in cycles 1+133s .. 128+133s.
- rd_en cycle t gives wr_en in cycle t+WB_DLY (t+5 by default) and tw_idx valid in cycle t+RD_LAT.
- Default last issue is cycle 1059 and last wr_en is cycle 1064. done=1 and busy=0 in cycle 1065.
- busy is high in cycles 1..1064.
- Totals: 1024 rd_en cycles and 1024 wr_en cycles per transform.
- Each en=0 cycle extends every subsequent event by exactly one cycle.
- start in the same cycle as done/IDLE entry is not accepted; the next cycle's start is.

## Test plan
- Reset then idle: reset_n low mid-clock gives all outputs 0 immediately. With start=0 for 20 cycles, rd_en, wr_en, busy and done all stay 0.
- Stage 0 sequence: start, then cycle 1 gives A=0, B=1, tw=0 and cycle 2 gives A=2, B=3, tw=0. First wr_en in cycle 6 with wr A=0, B=1.
- Mid-stage addresses:
  - Stage 3, k=9: A=17, B=25, tw_idx=16.
  - Stage 7, k=5: A=5, B=133, tw_idx=5.
  - Scoreboard every stage so each address 0..255 is written exactly once per stage.
- Full run: count 1024 rd_en and 1024 wr_en; single done pulse in cycle 1065. A second start while busy (cycle 500) has no effect.
- Stall: en=0 for 3 cycles at cycle 130 (stage 0 drain) freezes all outputs. done moves to cycle 1068 and the stage 0→1 read/write gap is preserved.
- Abort: reset_n low at cycle 700 gives all outputs 0 and IDLE. A new start then replays from stage 0, k=0 with correct timing.
